// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM states and D/E control-bundle layout for the hazard unit.
package hazard_pkg;
    typedef enum logic {RUN, MEM_WAIT} state_t;
    localparam int CTRL_W = 2;
    localparam int MEMTOREG_BIT = 0;
    localparam int REGWR_BIT = 1;
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
    function automatic logic is_load_wr(input logic [CTRL_W-1:0] c);
        return c[MEMTOREG_BIT] & c[REGWR_BIT];
    endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-side fields in, stall/flush controls out of the hazard unit.
interface hazard_unit_if import hazard_pkg::*; #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W = 16
);
    logic dec_valid;
    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [REG_ADDR_W-1:0] dec_rs2;
    logic dec_uses_rs1;
    logic dec_uses_rs2;
    logic ex_mem_read;
    logic ex_reg_write;
    logic [REG_ADDR_W-1:0] ex_write_add;
    logic ex_branch_taken;
    logic mem_start;
    logic pc_stall;
    logic fd_stall;
    logic fd_flush;
    logic de_stall;
    logic de_flush;
    logic em_stall;
    logic mw_flush;
    logic mem_done;
    logic busy;
    logic [CNT_W-1:0] stall_cycles;
    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
               ex_mem_read, ex_reg_write, ex_write_add, ex_branch_taken, mem_start,
        input  pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall,
               mw_flush, mem_done, busy, stall_cycles
    );
    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
               ex_mem_read, ex_reg_write, ex_write_add, ex_branch_taken, mem_start,
        output pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall,
               mw_flush, mem_done, busy, stall_cycles
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: enable-driven up counter that sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (en && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use bubbles, taken-branch flushes and multi-cycle memory stalls
// for the F/D, D/E, E/M and M/W buffers, plus a saturating stall-cycle counter.
module hazard_unit import hazard_pkg::*; #(
    parameter int REG_ADDR_W = 3,
    parameter int MEM_LAT = 2,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    hazard_unit_if.slave bus
);
    generate
        if (MEM_LAT < 2) begin : g_bad_lat
            $error("hazard_unit: MEM_LAT must be >= 2");
        end
    endgenerate
    localparam int WCW = MEM_LAT > 2 ? $clog2(MEM_LAT - 1) : 1;
    state_t state, state_nx;
    logic [WCW-1:0] wcnt, wcnt_nx;
    logic ack, ack_nx;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [REG_ADDR_W-1:0] rs1, rs2, wa;
    logic ms, br, dep, run, stall_all, branch, load_use, pc_stall;
    logic [CNT_W-1:0] cnt;
    assign rs1 = bus.dec_rs1;
    assign rs2 = bus.dec_rs2;
    assign wa = bus.ex_write_add;
    // Gating every input with rst makes all outputs decode to zero during reset.
    always_comb begin
        ex_ctrl = CTRL_NOP;
        ex_ctrl[MEMTOREG_BIT] = bus.ex_mem_read & ~rst;
        ex_ctrl[REGWR_BIT] = bus.ex_reg_write & ~rst;
    end
    assign ms = bus.mem_start & ~rst;
    assign br = bus.ex_branch_taken & ~rst;
    assign dep = ~rst & bus.dec_valid & is_load_wr(ex_ctrl)
               & ((bus.dec_uses_rs1 & (rs1 == wa)) | (bus.dec_uses_rs2 & (rs2 == wa)));
    assign run = state == RUN;
    assign stall_all = (run & ms & ~ack) | ~run;
    assign branch = ~stall_all & br;
    assign load_use = ~stall_all & ~br & dep;
    assign pc_stall = stall_all | load_use;
    assign bus.pc_stall = pc_stall;
    assign bus.fd_stall = pc_stall;
    assign bus.fd_flush = branch;
    assign bus.de_stall = stall_all;
    assign bus.de_flush = branch | load_use;
    assign bus.em_stall = stall_all;
    assign bus.mw_flush = stall_all;
    assign bus.mem_done = run & ack;
    assign bus.busy = ~run;
    assign bus.stall_cycles = cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            wcnt <= '0;
            ack <= 1'b0;
        end else begin
            state <= state_nx;
            wcnt <= wcnt_nx;
            ack <= ack_nx;
        end
    end
    // ack marks the single RUN cycle where the finished M op is still present.
    always_comb begin
        state_nx = state;
        wcnt_nx = wcnt;
        ack_nx = 1'b0;
        if (run) begin
            state_nx = (ms & ~ack) ? MEM_WAIT : RUN;
            wcnt_nx = (ms & ~ack) ? WCW'(MEM_LAT - 2) : wcnt;
        end else if (wcnt == '0) begin
            state_nx = RUN;
            ack_nx = 1'b1;
        end else begin
            wcnt_nx = wcnt - 1'b1;
        end
    end
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .en(pc_stall),
        .count(cnt)
    );
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: drives MEM_LAT=2/CNT_W=16 and MEM_LAT=4/CNT_W=4 instances with
// identical stimulus and scores both against a cycle model.
module tb_hazard_unit;
    typedef struct packed {
        logic dv;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic u1;
        logic u2;
        logic mr;
        logic rw;
        logic [2:0] wa;
        logic br;
        logic ms;
    } in_t;
    typedef struct {
        logic [8:0] ctl;
        int cnt;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t cur = '0;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    int left[2];
    bit done[2];
    int mcnt[2];
    int lat[2] = '{2, 4};
    int mx[2] = '{65535, 15};
    hazard_unit_if #(.REG_ADDR_W(3), .CNT_W(16)) bus0 ();
    hazard_unit_if #(.REG_ADDR_W(3), .CNT_W(4)) bus1 ();
    hazard_unit #(.REG_ADDR_W(3), .MEM_LAT(2), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    hazard_unit #(.REG_ADDR_W(3), .MEM_LAT(4), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    always #5 clk = ~clk;
    always_comb begin
        bus0.dec_valid = cur.dv;
        bus0.dec_rs1 = cur.rs1;
        bus0.dec_rs2 = cur.rs2;
        bus0.dec_uses_rs1 = cur.u1;
        bus0.dec_uses_rs2 = cur.u2;
        bus0.ex_mem_read = cur.mr;
        bus0.ex_reg_write = cur.rw;
        bus0.ex_write_add = cur.wa;
        bus0.ex_branch_taken = cur.br;
        bus0.mem_start = cur.ms;
        bus1.dec_valid = cur.dv;
        bus1.dec_rs1 = cur.rs1;
        bus1.dec_rs2 = cur.rs2;
        bus1.dec_uses_rs1 = cur.u1;
        bus1.dec_uses_rs2 = cur.u2;
        bus1.ex_mem_read = cur.mr;
        bus1.ex_reg_write = cur.rw;
        bus1.ex_write_add = cur.wa;
        bus1.ex_branch_taken = cur.br;
        bus1.mem_start = cur.ms;
    end
    wire [8:0] ctl0 = {bus0.pc_stall, bus0.fd_stall, bus0.fd_flush, bus0.de_stall, bus0.de_flush,
                       bus0.em_stall, bus0.mw_flush, bus0.mem_done, bus0.busy};
    wire [8:0] ctl1 = {bus1.pc_stall, bus1.fd_stall, bus1.fd_flush, bus1.de_stall, bus1.de_flush,
                       bus1.em_stall, bus1.mw_flush, bus1.mem_done, bus1.busy};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask
    task automatic compare_all(input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, "/ctl0"}, 32'(ctl0), 32'(e.ctl));
        check({tag, "/cnt0"}, 32'(bus0.stall_cycles), e.cnt);
        e = sb.pop_front();
        check({tag, "/ctl1"}, 32'(ctl1), 32'(e.ctl));
        check({tag, "/cnt1"}, 32'(bus1.stall_cycles), e.cnt);
    endtask
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            left[d] = 0;
            done[d] = 1'b0;
            mcnt[d] = 0;
        end
    endtask
    // ctl order: pc_stall fd_stall fd_flush de_stall de_flush em_stall mw_flush mem_done busy
    task automatic step(input string tag, input in_t s);
        @(posedge clk);
        #1;
        cur = s;
        for (int d = 0; d < 2; d++) begin
            logic st, bb, lu;
            st = (left[d] > 0) || (!done[d] && s.ms);
            bb = !st && s.br;
            lu = !st && !s.br && s.dv && s.mr && s.rw
                 && ((s.u1 && s.rs1 == s.wa) || (s.u2 && s.rs2 == s.wa));
            sb.push_back('{{st | lu, st | lu, bb, st, bb | lu, st, st, done[d], left[d] > 0}, mcnt[d]});
            if ((st || lu) && mcnt[d] < mx[d]) mcnt[d]++;
            if (left[d] > 0) begin
                left[d]--;
                if (left[d] == 0) done[d] = 1'b1;
            end else if (done[d]) done[d] = 1'b0;
            else if (s.ms) left[d] = lat[d] - 1;
        end
        #3;
        compare_all(tag);
    endtask
    initial begin
        in_t s;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        s = '0;
        step("idle", s);
        s.dv = 1; s.u1 = 1; s.rs1 = 3; s.mr = 1; s.rw = 1; s.wa = 3;
        step("lu_rs1", s);
        s.mr = 0; s.rw = 0;
        step("bubble", s);
        s.mr = 1; s.rw = 1; s.rs1 = 4;
        step("lu_nomatch", s);
        s.u1 = 0; s.u2 = 1; s.rs2 = 3;
        step("lu_rs2", s);
        s.u2 = 0; s.u1 = 1; s.rs1 = 0; s.wa = 0;
        step("lu_addr0", s);
        s.rw = 0;
        step("lu_noregwr", s);
        s.rw = 1; s.dv = 0;
        step("lu_invalid", s);
        s.dv = 1; s.br = 1;
        step("br_over_lu", s);
        s = '0;
        step("idle2", s);
        s.ms = 1;
        repeat (5) step("mem", s);
        s = '0;
        repeat (3) step("mem_idle", s);
        s.ms = 1; s.br = 1;
        repeat (5) step("overlap", s);
        s = '0;
        repeat (3) step("ov_idle", s);
        for (int i = 0; i < 40; i++) begin
            s.dv = 1'($urandom_range(0, 1));
            s.rs1 = 3'($urandom_range(0, 3));
            s.rs2 = 3'($urandom_range(0, 3));
            s.u1 = 1'($urandom_range(0, 1));
            s.u2 = 1'($urandom_range(0, 1));
            s.mr = 1'($urandom_range(0, 1));
            s.rw = 1'($urandom_range(0, 1));
            s.wa = 3'($urandom_range(0, 3));
            s.br = ($urandom_range(0, 4) == 0);
            s.ms = ($urandom_range(0, 5) == 0);
            step("rand", s);
        end
        s = '0;
        s.ms = 1;
        repeat (20) step("sat", s);
        s = '0;
        repeat (6) step("pre_rst", s);
        s.ms = 1;
        step("rst_a", s);
        s.ms = 0;
        step("rst_b", s);
        step("rst_c", s);
        #2;
        cur = '{1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1};
        rst = 1'b1;
        #1;
        model_reset();
        sb.push_back('{9'd0, 0});
        sb.push_back('{9'd0, 0});
        compare_all("in_rst");
        #10;
        cur = '0;
        rst = 1'b0;
        s = '0;
        repeat (3) step("post_rst", s);
        s.ms = 1;
        repeat (5) step("post_rst_mem", s);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block that drives the stall and flush inputs of the F/D, D/E, E/M and M/W buffers.
- Consumes decode-stage source fields and the D/E buffer's registered outputs (execute-stage control and write address); it is the consumer-side counterpart that decides when the D/E buffer loads, holds or loads a bubble.
- Handles load-use bubbles, taken-branch flushes and multi-cycle memory-stage stalls.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 3: register address width.
- MEM_LAT, 2: number of stall cycles for a multi-cycle memory op. Legal values are ≥2; elaboration error otherwise.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- dec_valid  in  1  decode stage holds a real instruction.
- dec_rs1  in  REG_ADDR_W  decode source register 1.
- dec_rs2  in  REG_ADDR_W  decode source register 2.
- dec_uses_rs1  in  1  instruction reads rs1.
- dec_uses_rs2  in  1  instruction reads rs2.
- ex_mem_read  in  1  execute-stage MemtoReg bit from the D/E buffer.
- ex_reg_write  in  1  execute-stage RegWr bit from the D/E buffer.
- ex_write_add  in  REG_ADDR_W  execute-stage write address from the D/E buffer.
- ex_branch_taken  in  1  execute resolved a taken branch.
- mem_start  in  1  memory stage holds a multi-cycle op (load, store, push, pop).
- pc_stall  out  1  PC holds.
- fd_stall  out  1  F/D buffer holds.
- fd_flush  out  1  F/D buffer loads NOP.
- de_stall  out  1  D/E buffer holds.
- de_flush  out  1  D/E buffer loads all-zero control (bubble).
- em_stall  out  1  E/M buffer holds.
- mw_flush  out  1  M/W buffer loads bubble.
- mem_done  out  1  single-cycle pulse: the memory op completes and M advances.
- busy  out  1  FSM is in MEM_WAIT.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1.

Behaviour:
- Reset (async, immediate on rst rise):
  - state=RUN, wait counter=0, ack flag=0, stall_cycles=0.
  - All outputs are 0 while rst=1, because they are decoded from RUN with inputs gated by rst.
- States:
  - RUN: normal flow.
  - MEM_WAIT: frozen for a memory op.
- stall_all = (RUN & mem_start & ~ack) | MEM_WAIT.
- RUN → MEM_WAIT on mem_start & ~ack; the wait counter loads MEM_LAT-2.
- MEM_WAIT:
  - If counter==0, go to RUN and set ack=1.
  - Otherwise decrement the counter.
- stall_all is therefore high for exactly MEM_LAT consecutive cycles, starting the cycle mem_start is first sampled.
- ack is cleared after exactly one RUN cycle. In that cycle:
  - mem_done=1.
  - mem_start is ignored, because the same M instruction is still present.
- While stall_all=1:
  - pc_stall=fd_stall=de_stall=em_stall=1.
  - mw_flush=1.
  - fd_flush=de_flush=0.
  - Branch and load-use detection are suppressed; ex_branch_taken stays held by the stalled E stage and is acted on after the stall.
- Branch, when ~stall_all & ex_branch_taken:
  - fd_flush=1 and de_flush=1 in the same cycle.
  - Load-use is suppressed, since the decode instruction is being killed.
- Load-use:
  - Condition: ~stall_all & ~ex_branch_taken & dec_valid & ex_mem_read & ex_reg_write & ((dec_uses_rs1 & dec_rs1==ex_write_add) | (dec_uses_rs2 & dec_rs2==ex_write_add)).
  - Response: pc_stall=fd_stall=1, de_flush=1, de_stall=0.
  - Exactly one bubble results. Next cycle E holds the bubble, so there is no re-trigger.
- Priority: memory stall > branch flush > load-use.
- All hazard outputs are combinational from state and current inputs. State, counter, ack and stall_cycles are registered.
- stall_cycles increments on every cycle with pc_stall=1 and saturates at all-ones; it never wraps.
- Reset mid-MEM_WAIT aborts immediately to RUN. No mem_done pulse is issued.
- Register address 0 gets no special treatment: matches on address 0 count as hazards.

Decomposition:
- Shared package hazard_pkg:
  - state enum {RUN, MEM_WAIT}.
  - D/E control-bundle bit indices (MemtoReg, RegWr).
  - NOP/bubble control constant (all-zero).
- Sub-module sat_counter(WIDTH): enable-driven saturating counter, instantiated for stall_cycles.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_write_add=3, dec_valid=1, dec_uses_rs1=1, dec_rs1=3 → for one cycle pc_stall=fd_stall=de_flush=1, de_stall=0; stall_cycles 0→1. With dec_rs1=4 and dec_uses_rs2=0 → no stall.
- Branch: ex_branch_taken=1 for one cycle with a matching load-use also present → fd_flush=de_flush=1, pc_stall=0.
- Memory stall with MEM_LAT=2: mem_start held high → stall_all for cycles t and t+1, busy=1 at t+1, mem_done=1 at t+2 with no stall; stall_cycles=2. Repeat with MEM_LAT=4 → 4 stall cycles.
- Overlap: mem_start and ex_branch_taken both high at t → no flush during the stall; fd_flush=de_flush=1 in the mem_done cycle.
- Reset: assert rst at MEM_WAIT with counter=1 → all outputs 0 immediately, state=RUN, stall_cycles=0, no mem_done pulse after release.
- Saturation with CNT_W=4: hold a stall for 20 cycles → stall_cycles stops at 15.
